// File: rtl/vga_timing_gen.sv
// Raster timing generator: column/row scan counters with registered syncs,
// blanking and a frame-start strobe, all aligned to the counter values.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 1024,
  parameter int unsigned H_FP       = 24,
  parameter int unsigned H_SYNC     = 136,
  parameter int unsigned H_BP       = 160,
  parameter int unsigned V_ACTIVE   = 768,
  parameter int unsigned V_FP       = 3,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BP       = 29,
  parameter logic        H_SYNC_POL = 1'b0,
  parameter logic        V_SYNC_POL = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixel_en,
  output logic [11:0] pixel_column,
  output logic [11:0] pixel_row,
  output logic        horiz_sync,
  output logic        vert_sync,
  output logic        video_on,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // Region bounds are 13 bits so an end bound equal to 4096 still compares correctly.
  localparam logic [12:0] H_ACT_END    = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_START = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_END    = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_START = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYNC_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] column_q, column_d;
  logic [11:0] row_q, row_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_q, video_d;
  logic        frame_q, frame_d;

  logic [11:0] col_nxt, row_nxt;
  logic [12:0] col_ext, row_ext;

  // Next raster position, independent of the enable.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    col_nxt = column_q + 12'd1;
    row_nxt = row_q;
    if (column_q == H_LAST) begin
      col_nxt = '0;
      row_nxt = (row_q == V_LAST) ? '0 : row_q + 12'd1;
    end
  end

  assign col_ext = {1'b0, col_nxt};
  assign row_ext = {1'b0, row_nxt};

  // Decode from the next position so the flags land in the same cycle as the counters.
  always_comb begin
    column_d = column_q;
    row_d    = row_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    video_d  = video_q;
    frame_d  = frame_q;
    if (pixel_en) begin
      column_d = col_nxt;
      row_d    = row_nxt;
      hsync_d  = ((col_ext >= H_SYNC_START) && (col_ext < H_SYNC_END)) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_d  = ((row_ext >= V_SYNC_START) && (row_ext < V_SYNC_END)) ? V_SYNC_POL : ~V_SYNC_POL;
      video_d  = (col_ext < H_ACT_END) && (row_ext < V_ACT_END);
      frame_d  = (col_nxt == '0) && (row_nxt == '0);
    end
  end

  // Reset parks the counters on the last position so the first enabled step yields (0,0).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      column_q <= H_LAST;
      row_q    <= V_LAST;
      hsync_q  <= ~H_SYNC_POL;
      vsync_q  <= ~V_SYNC_POL;
      video_q  <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops sample pre-edge values.
      column_q <= column_d;
      row_q    <= row_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      video_q  <= video_d;
      frame_q  <= frame_d;
    end
  end

  assign pixel_column = column_q;
  assign pixel_row    = row_q;
  assign horiz_sync   = hsync_q;
  assign vert_sync    = vsync_q;
  assign video_on     = video_q;
  assign frame_start  = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a default 1024x768 instance and a small-parameter instance,
// compared against a raster model computed from the enabled-step count.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [11:0] col;
    logic [11:0] row;
    logic        hs;
    logic        vs;
    logic        vo;
    logic        fs;
  } out_t;

  typedef struct {
    logic rst;
    logic en;
    out_t exp;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_b, en_b, rst_s, en_s;
  logic [11:0] col_b, row_b, col_s, row_s;
  logic        hs_b, vs_b, vo_b, fs_b;
  logic        hs_s, vs_s, vo_s, fs_s;

  int     errors = 0;
  int     checks = 0;
  longint k_b = 0;
  longint k_s = 0;

  vga_timing_gen dut_big (
    .clock(clock), .reset(rst_b), .pixel_en(en_b),
    .pixel_column(col_b), .pixel_row(row_b),
    .horiz_sync(hs_b), .vert_sync(vs_b), .video_on(vo_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_small (
    .clock(clock), .reset(rst_s), .pixel_en(en_s),
    .pixel_column(col_s), .pixel_row(row_s),
    .horiz_sync(hs_s), .vert_sync(vs_s), .video_on(vo_s), .frame_start(fs_s)
  );

  function automatic out_t mk(int c, int r, bit hs, bit vs, bit vo, bit fs);
    out_t o;
    o.col = 12'(c); o.row = 12'(r);
    o.hs = hs; o.vs = vs; o.vo = vo; o.fs = fs;
    return o;
  endfunction

  // Position is a linear index into the frame: k enabled steps after reset.
  function automatic out_t model(longint k, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, bit hp, bit vp);
    int     ht = ha + hf + hsw + hb;
    int     vt = va + vf + vsw + vb;
    longint frame = longint'(ht) * vt;
    longint idx = (frame - 1 + k) % frame;
    int     c = int'(idx % ht);
    int     r = int'(idx / ht);
    bit     hs_on = (c >= ha + hf) && (c < ha + hf + hsw);
    bit     vs_on = (r >= va + vf) && (r < va + vf + vsw);
    return mk(c, r, hs_on ? hp : !hp, vs_on ? vp : !vp,
              (c < ha) && (r < va), (k > 0) && (idx == 0));
  endfunction

  function automatic out_t model_b(longint k);
    return model(k, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0);
  endfunction

  function automatic out_t model_s(longint k);
    return model(k, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1);
  endfunction

  function automatic out_t big_now();
    return mk(int'(col_b), int'(row_b), hs_b, vs_b, vo_b, fs_b);
  endfunction

  function automatic out_t small_now();
    return mk(int'(col_s), int'(row_s), hs_s, vs_s, vo_s, fs_s);
  endfunction

  task automatic check(string name, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got col=%0d row=%0d hs=%b vs=%b vo=%b fs=%b, want col=%0d row=%0d hs=%b vs=%b vo=%b fs=%b",
               name, act.col, act.row, act.hs, act.vs, act.vo, act.fs,
               exp.col, exp.row, exp.hs, exp.vs, exp.vo, exp.fs);
    end
  endtask

  task automatic check_val(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One clock edge; inputs were driven at the previous edge + 1, outputs sampled at edge + 1.
  task automatic tick();
    @(posedge clock);
    if (rst_b) k_b = 0; else if (en_b) k_b++;
    if (rst_s) k_s = 0; else if (en_s) k_s++;
    #1;
  endtask

  vec_t vecs[13];
  out_t saved;
  int   hs_low;
  bit   found;

  initial begin
    vecs[0]  = '{1'b1, 1'b1, mk(15, 7, 0, 0, 0, 0)};
    vecs[1]  = '{1'b0, 1'b1, mk(0, 0, 0, 0, 1, 1)};
    vecs[2]  = '{1'b0, 1'b0, mk(0, 0, 0, 0, 1, 1)};
    vecs[3]  = '{1'b0, 1'b1, mk(1, 0, 0, 0, 1, 0)};
    vecs[4]  = '{1'b0, 1'b1, mk(2, 0, 0, 0, 1, 0)};
    vecs[5]  = '{1'b0, 1'b1, mk(3, 0, 0, 0, 1, 0)};
    vecs[6]  = '{1'b0, 1'b0, mk(3, 0, 0, 0, 1, 0)};
    vecs[7]  = '{1'b0, 1'b1, mk(4, 0, 0, 0, 1, 0)};
    vecs[8]  = '{1'b0, 1'b1, mk(5, 0, 0, 0, 1, 0)};
    vecs[9]  = '{1'b0, 1'b1, mk(6, 0, 0, 0, 1, 0)};
    vecs[10] = '{1'b0, 1'b1, mk(7, 0, 0, 0, 1, 0)};
    vecs[11] = '{1'b0, 1'b1, mk(8, 0, 0, 0, 0, 0)};
    vecs[12] = '{1'b0, 1'b1, mk(9, 0, 0, 0, 0, 0)};

    rst_b = 1'b1; en_b = 1'b0;
    rst_s = 1'b1; en_s = 1'b0;
    #1;

    // Small instance: table vectors covering reset, first step, strobe stretch, video edge.
    for (int i = 0; i < 13; i++) begin
      rst_s = vecs[i].rst;
      en_s  = vecs[i].en;
      tick();
      check($sformatf("vec%0d", i), small_now(), vecs[i].exp);
    end
    en_s = 1'b1;
    tick();
    check("small_hsync_on_10", small_now(), mk(10, 0, 1, 0, 0, 0));

    // Small instance: random enable with occasional reset, against the model.
    for (int i = 0; i < 1500; i++) begin
      en_s  = ($urandom_range(0, 3) != 0);
      rst_s = ($urandom_range(0, 299) == 0);
      tick();
      check("rand_small", small_now(), model_s(k_s));
    end

    // Small instance: full frame from (0,0) returns to (0,0) with the strobe.
    rst_s = 1'b1; en_s = 1'b1;
    tick();
    rst_s = 1'b0;
    tick();
    check("small_frame_origin", small_now(), mk(0, 0, 0, 0, 1, 1));
    for (int i = 0; i < 128; i++) begin
      tick();
      check("small_frame_run", small_now(), model_s(k_s));
    end
    check("small_frame_period", small_now(), mk(0, 0, 0, 0, 1, 1));

    // Small instance: async reset while both syncs are asserted.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      check("small_seek", small_now(), model_s(k_s));
      if (model_s(k_s).col == 12'd11 && model_s(k_s).row == 12'd5) found = 1'b1;
    end
    check_val("small_seek_reached", int'(found), 1);
    check_val("small_both_sync_on", int'({hs_s, vs_s}), 3);
    #2 rst_s = 1'b1;
    #1 check("small_async_reset", small_now(), mk(15, 7, 0, 0, 0, 0));
    k_s = 0;
    tick();
    check("small_reset_held", small_now(), mk(15, 7, 0, 0, 0, 0));
    rst_s = 1'b0;
    tick();
    check("small_restart", small_now(), mk(0, 0, 0, 0, 1, 1));
    en_s = 1'b0;

    // Default instance: reset and first steps.
    rst_b = 1'b1; en_b = 1'b1;
    tick();
    check("big_reset", big_now(), mk(1343, 805, 1, 1, 0, 0));
    rst_b = 1'b0;
    tick();
    check("big_first", big_now(), mk(0, 0, 1, 1, 1, 1));
    tick();
    check("big_second", big_now(), mk(1, 0, 1, 1, 1, 0));

    // Default instance: row 0 and the wrap into row 1.
    hs_low = 0;
    while (k_b < 1345) begin
      tick();
      check("big_row0", big_now(), model_b(k_b));
      if (k_b <= 1344 && hs_b == 1'b0) hs_low++;
      if (k_b == 1025) check_val("big_video_fall_1024", int'(vo_b), 0);
      if (k_b == 1048) check_val("big_hsync_1047", int'(hs_b), 1);
      if (k_b == 1049) check_val("big_hsync_1048", int'(hs_b), 0);
      if (k_b == 1184) check_val("big_hsync_1183", int'(hs_b), 0);
      if (k_b == 1185) check_val("big_hsync_1184", int'(hs_b), 1);
    end
    check_val("big_hsync_width", hs_low, 136);
    check("big_hwrap", big_now(), mk(0, 1, 1, 1, 1, 0));

    // Default instance: stall at column 1047 of row 1.
    while (k_b < 1344 + 1048) begin
      tick();
      check("big_row1", big_now(), model_b(k_b));
    end
    check("big_at_1047", big_now(), mk(1047, 1, 1, 1, 0, 0));
    saved = big_now();
    en_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("big_stall", big_now(), saved);
      check_val("big_stall_hsync", int'(hs_b), 1);
    end
    en_b = 1'b1;
    tick();
    check("big_resume", big_now(), mk(1048, 1, 0, 1, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Display timing generator; the producer side of the pixel-address interface that robot_icon and the other icon/colorizer blocks consume.
- Generates pixel_column/pixel_row scan counters, horizontal/vertical sync, video_on blanking and a frame-start strobe.
- Defaults give 1024x768 @ 60 Hz from a 65 MHz pixel clock.
- Sits between the clock wizard and the colorizer/VGA pins.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of horiz_sync
- V_SYNC_POL, 0, asserted level of vert_sync

Ports:
- clock  input  1  pixel clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- pixel_en  input  1  advance enable; counters step only on edges where pixel_en=1
- pixel_column  output  12  current horizontal count, 0..H_TOTAL-1
- pixel_row  output  12  current vertical count, 0..V_TOTAL-1
- horiz_sync  output  1  horizontal sync, polarity per H_SYNC_POL
- vert_sync  output  1  vertical sync, polarity per V_SYNC_POL
- video_on  output  1  1 when (column,row) is inside the active area
- frame_start  output  1  one-cycle strobe when counters become (0,0)

Behaviour:
- Interface (already decided): one clock, named clock; reset is asynchronous and active-high, named reset.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806).
- Registers: every output is a flop. No combinational path from any input to any output.
- Reset values (asynchronous): pixel_column=H_TOTAL-1, pixel_row=V_TOTAL-1, video_on=0, frame_start=0, horiz_sync=~H_SYNC_POL, vert_sync=~V_SYNC_POL. This means the first enabled edge after reset lands on (0,0).
- Step on each edge with pixel_en=1:
  - column == H_TOTAL-1: column <= 0.
    - If row == V_TOTAL-1, then row <= 0; otherwise row <= row+1.
  - Otherwise: column <= column+1 and row holds.
- Alignment: horiz_sync, vert_sync, video_on and frame_start are computed from the next counter values, so they are cycle-aligned with pixel_column/pixel_row. Zero latency relative to the counters.
- horiz_sync asserted iff H_ACTIVE+H_FP <= column < H_ACTIVE+H_FP+H_SYNC (1048..1183).
- vert_sync asserted iff V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC (771..776). Evaluated on row only, so it changes at the column wrap.
- video_on = (column < H_ACTIVE) && (row < V_ACTIVE).
- frame_start = 1 for exactly one enabled step, the step where the next state is (0,0). It clears on the next enabled step.
- pixel_en=0: all outputs hold their values, including frame_start. A strobe therefore stretches across stalled cycles. Consumers qualify it with pixel_en.
- Counter width: 12 bits. Parameters must satisfy H_TOTAL, V_TOTAL <= 4096. Counters never exceed TOTAL-1; there is no 12-bit wrap.
- Reset asserted mid-frame: immediate asynchronous return to the reset values. No partial sync pulse is held beyond the reset edge.
- pixel_row/pixel_column keep counting through blanking. Downstream blocks gate with video_on.

Test Plan:
- Reset: hold reset with pixel_en=1 -> column=1343, row=805, video_on=0, hsync=1, vsync=1, frame_start=0. Release, one edge -> (0,0), video_on=1, frame_start=1. Next edge -> (1,0), frame_start=0.
- Horizontal sync: run row 0 -> video_on falls at column 1024. hsync=0 for columns 1048..1183 (136 cycles) and returns to 1 at 1184. Column 1343 -> 0 with row 0 -> 1.
- Vertical sync and frame wrap: run a full frame -> vsync=0 on rows 771..776 (6x1344 cycles). (1343,805) -> (0,0) with frame_start=1. Frame period is exactly 1,083,264 enabled cycles.
- Enable stall: at column 1047 drop pixel_en for 5 cycles -> all outputs frozen, hsync still 1. Raise pixel_en -> column 1048, hsync=0.
- Reset mid-frame: assert reset asynchronously at (1100,773) while both syncs are active -> outputs return to the reset values before the next clock edge. Release -> restart at (0,0).
- Small parameter set: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1, both polarities=1 -> hsync high on columns 10..12, vsync high on rows 5..6, H_TOTAL=16, V_TOTAL=8.
